// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver.
// Segment vectors are ordered {g,f,e,d,c,b,a} (bit 6 = g, bit 0 = a) and
// are active-low: a 0 bit lights the segment.
package seg_pkg;

  typedef logic [6:0] seg_t;

  // Bit position of each segment inside a seg_t.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // All segments dark.
  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t GLYPH_0 = 7'b1000000;
  localparam seg_t GLYPH_1 = 7'b1111001;
  localparam seg_t GLYPH_2 = 7'b0100100;
  localparam seg_t GLYPH_3 = 7'b0110000;
  localparam seg_t GLYPH_4 = 7'b0011001;
  localparam seg_t GLYPH_5 = 7'b0010010;
  localparam seg_t GLYPH_6 = 7'b0000010;
  localparam seg_t GLYPH_7 = 7'b1111000;
  localparam seg_t GLYPH_8 = 7'b0000000;
  localparam seg_t GLYPH_9 = 7'b0010000;
  localparam seg_t GLYPH_A = 7'b0001000;
  localparam seg_t GLYPH_B = 7'b0000011;
  localparam seg_t GLYPH_C = 7'b1000110;
  localparam seg_t GLYPH_D = 7'b0100001;
  localparam seg_t GLYPH_E = 7'b0000110;
  localparam seg_t GLYPH_F = 7'b0001110;

endpackage

// File: rtl/seg_hex_decode.sv
// Hex code to 7-segment glyph decoder (combinational).
// Ports:
//   code  in  4  hex value 0..F
//   glyph out 7  active-low segments {g,f,e,d,c,b,a}
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = SEG_BLANK;
    case (code)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      4'hF: glyph = GLYPH_F;
      default: glyph = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment display scanner.
// Each digit owns a slot of 2^DIV_LOG2 clk cycles; NUM_DIGITS slots form a
// frame. Display inputs are frozen into a snapshot at frame start so a frame
// never shows a mix of old and new values. Brightness is PWM on the anodes
// within each slot; blinking digits go dark on alternate blink phases.
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   nums         in   4 bits per digit, digit 0 in nums[3:0] (rightmost)
//   dp_in        in   decimal point request per digit (1 = lit)
//   blank        in   force digit dark
//   blink        in   digit dark while blink phase is 1
//   lz_en        in   leading-zero suppression enable
//   bright       in   0 = 1/8 duty .. 7 = full duty
//   digit        out  one-hot-low anode select
//   seg          out  active-low {g,f,e,d,c,b,a}
//   dp           out  active-low decimal point
//   frame_start  out  one-clk pulse with the first output of digit 0
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_LOG2   = 16,
  parameter int BLINK_LOG2 = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] nums,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic                    lz_en,
  input  logic [2:0]              bright,
  output logic [NUM_DIGITS-1:0]   digit,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_LOG2-1:0] SLOT_LAST = '1;

  logic [DIV_LOG2-1:0]   slot_cnt;
  logic [IDX_W-1:0]      idx;
  logic [BLINK_LOG2-1:0] frame_cnt;
  logic                  blink_phase;

  logic [4*NUM_DIGITS-1:0] snap_nums;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_blank;
  logic [NUM_DIGITS-1:0]   snap_blink;
  logic                    snap_lz;
  logic [2:0]              bright_q;

  logic slot_start;
  logic slot_wrap;
  logic frame_begin;
  logic frame_end;

  assign slot_start  = (slot_cnt == '0);
  assign slot_wrap   = (slot_cnt == SLOT_LAST);
  assign frame_begin = slot_start && (idx == '0);
  assign frame_end   = slot_wrap && (idx == IDX_LAST);

  // Counters, snapshot and per-slot brightness.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt    <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      snap_nums   <= '0;
      snap_dp     <= '0;
      snap_blank  <= '0;
      snap_blink  <= '0;
      snap_lz     <= 1'b0;
      bright_q    <= '0;
    end else begin
      slot_cnt <= slot_cnt + DIV_LOG2'(1);
      if (slot_wrap) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end
      // Phase changes only between frames so a frame is never half-blinked.
      if (frame_end) begin
        frame_cnt <= frame_cnt + BLINK_LOG2'(1);
        if (frame_cnt == '1) begin
          blink_phase <= ~blink_phase;
        end
      end
      if (frame_begin) begin
        snap_nums  <= nums;
        snap_dp    <= dp_in;
        snap_blank <= blank;
        snap_blink <= blink;
        snap_lz    <= lz_en;
      end
      if (slot_start) begin
        bright_q <= bright;
      end
    end
  end

  // On the capture cycle itself the registers still hold the previous value,
  // so the live inputs are forwarded to keep the output one cycle behind
  // the counters without an extra pipeline stage.
  logic [4*NUM_DIGITS-1:0] eff_nums;
  logic [NUM_DIGITS-1:0]   eff_dp;
  logic [NUM_DIGITS-1:0]   eff_blank;
  logic [NUM_DIGITS-1:0]   eff_blink;
  logic                    eff_lz;
  logic [2:0]              eff_bright;

  always_comb begin
    eff_nums   = frame_begin ? nums  : snap_nums;
    eff_dp     = frame_begin ? dp_in : snap_dp;
    eff_blank  = frame_begin ? blank : snap_blank;
    eff_blink  = frame_begin ? blink : snap_blink;
    eff_lz     = frame_begin ? lz_en : snap_lz;
    eff_bright = slot_start ? bright : bright_q;
  end

  // A digit is suppressed while every digit from the leftmost down to it is
  // zero; digit 0 always shows so a zero value still reads "0".
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_run;

  always_comb begin
    lz_mask  = '0;
    zero_run = eff_lz;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run && (eff_nums[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_run;
    end
  end

  logic [3:0] cur_code;
  logic       cur_dp;
  logic       cur_dark;

  always_comb begin
    cur_code = 4'h0;
    cur_dp   = 1'b0;
    cur_dark = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_code = eff_nums[4*i +: 4];
        cur_dp   = eff_dp[i];
        cur_dark = eff_blank[i] || (eff_blink[i] && blink_phase) || lz_mask[i];
      end
    end
  end

  logic [6:0] cur_glyph;

  seg_hex_decode u_dec (
    .code  (cur_code),
    .glyph (cur_glyph)
  );

  // PWM: the top three slot bits split each slot into eighths.
  logic                  anode_on;
  logic [NUM_DIGITS-1:0] digit_nxt;

  always_comb begin
    anode_on  = (slot_cnt[DIV_LOG2-1 -: 3] <= eff_bright);
    digit_nxt = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (anode_on && (idx == IDX_W'(i))) begin
        digit_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit       <= '1;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      digit       <= digit_nxt;
      seg         <= cur_dark ? SEG_BLANK : cur_glyph;
      dp          <= cur_dark ? 1'b1 : ~cur_dp;
      frame_start <= frame_begin;
    end
  end

endmodule
